dump_sequencer: RTL
===================

Name: dump_sequencer

Overview:
Sequences a channel dump from capture RAM out the UART. On a dump request it fetches the offset and gain calibration bytes for the selected channel and AFE gain from the calibration EEPROM over the shared SPI master. It then streams every capture-RAM sample, oldest first, to the UART transmitter and pulses dump_done. It sits beside the command decoder, which raises dump/dump_ch, and it drives the flopOffset/flopGain strobes that load the gain-corrector registers.

Parameters:
DEPTH, 512, capture RAM entries
AW, 9, RAM address width (log2 DEPTH)
EEP_SS, 3'b100, slave select for the calibration EEPROM
SPI_DUMMY, 16'hBCBC, filler word shifted out to retrieve EEPROM read data

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
dump  in  1  single-cycle dump request
dump_ch  in  2  channel to dump (0..2 valid, 3 reserved)
ch1_AFEgain, ch2_AFEgain, ch3_AFEgain  in  3 each  current AFE gain codes
trig_addr  in  AW  RAM address of the last sample written
wrt_SPI  out  1  SPI start pulse
SPI_data  out  16  SPI command word
ss  out  3  slave select
SPI_done  in  1  SPI transaction complete pulse
EEP_data  in  8  EEPROM read byte, valid with SPI_done
flopOffset  out  1  load offset register from EEP_data
flopGain  out  1  load gain register from EEP_data
ram_addr  out  AW  capture RAM read address
ram_en  out  1  RAM read enable
smpl  in  8  gain-corrected sample, valid 1 cycle after ram_en
tx_data  out  8  UART byte
trmt  out  1  UART transmit pulse
tx_done  in  1  UART byte sent pulse
busy  out  1  high from dump acceptance until dump_done
dump_done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; sample counter 0.
- Clock and reset: reset rst_n, asynchronous, active-low; clock clk.
- EEPROM address: cal_addr = {dump_ch, g, sel}, 6 bits.
  - g is the AFE gain code of the selected channel.
  - sel = 0 selects offset; sel = 1 selects gain.
- States and transitions:
  - IDLE: dump=1 latches dump_ch and g, sets busy, and goes to OFF_CMD.
    - If dump_ch = 3, go to ERR instead.
  - OFF_CMD: one-cycle wrt_SPI with ss=EEP_SS, SPI_data = {2'b00, cal_addr(sel=0), 8'h00}; go to OFF_W1.
  - OFF_W1: on SPI_done, pulse wrt_SPI with SPI_data = SPI_DUMMY; go to OFF_W2.
  - OFF_W2: on SPI_done, pulse flopOffset in the same cycle; go to GAIN_CMD.
  - GAIN_CMD / GAIN_W1 / GAIN_W2: identical sequence with sel=1, ending with a flopGain pulse; go to RD.
  - RD: ram_en=1, ram_addr = rd_ptr; go to LAT.
    - rd_ptr is initialised to trig_addr+1 modulo DEPTH (trig_addr = DEPTH-1 wraps to 0).
  - LAT: register smpl into tx_data and pulse trmt; go to TXW.
  - TXW: wait for tx_done.
    - Then increment the counter and rd_ptr (wrap at DEPTH-1 to 0).
    - If the counter has reached DEPTH, go to DONE; otherwise go back to RD.
  - DONE: one-cycle dump_done pulse, busy cleared; go to IDLE.
  - ERR: tx_data = 8'hEE, trmt pulse; wait for tx_done; then go to DONE.
- ss holds EEP_SS from OFF_CMD through GAIN_W2; it is 0 otherwise.
- wrt_SPI, trmt, flopOffset, flopGain and dump_done are single-cycle pulses.
- Exactly DEPTH bytes are sent per valid dump.
- dump asserted while busy is ignored.
- A SPI_done or tx_done that arrives in a state not waiting for it is ignored.
- Reset mid-operation returns to IDLE immediately; no dump_done is issued.

Optional Feature:
DUMP_HEADER_EN
- Defined: after GAIN_W2 the block first sends a header byte {6'b110100, dump_ch} (trmt, then wait for tx_done) before the first sample. A valid dump is then DEPTH+1 bytes.
- Undefined: no header; samples follow the calibration fetch directly.

Test Plan:
- Reset mid-dump (assert rst_n low during TXW) -> all outputs 0 next cycle, no dump_done, state IDLE; a new dump starts cleanly.
- dump, dump_ch=1, ch2_AFEgain=3'b101 -> SPI words 16'h1A00, 16'hBCBC, 16'h1B00, 16'hBCBC in order, all with ss=3'b100.
  - EEP_data 8'h12 loaded via flopOffset; EEP_data 8'h80 loaded via flopGain.
- trig_addr=9'd100, RAM model with data = addr[7:0] -> 512 UART bytes 8'd101..8'd255, 0..255, 0..100 in order; then exactly one dump_done; busy low afterwards.
- trig_addr=9'd511 -> first ram_addr 0 and last ram_addr 511; counter stops at 512.
- dump_ch=3 -> no wrt_SPI, single byte 8'hEE, then dump_done.
  - A second dump pulse issued while busy produces no extra traffic.

Source files
------------

// File: rtl/dump_sequencer.sv
// rtl/dump_sequencer.sv - fetches calibration over SPI, then streams capture RAM to the UART
// Optional header byte before the samples: define DUMP_HEADER_EN.
module dump_sequencer #(
  parameter int          DEPTH     = 512,
  parameter int          AW        = 9,
  parameter logic [2:0]  EEP_SS    = 3'b100,
  parameter logic [15:0] SPI_DUMMY = 16'hBCBC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump,
  input  logic [1:0]    dump_ch,
  input  logic [2:0]    ch1_AFEgain,
  input  logic [2:0]    ch2_AFEgain,
  input  logic [2:0]    ch3_AFEgain,
  input  logic [AW-1:0] trig_addr,
  output logic          wrt_SPI,
  output logic [15:0]   SPI_data,
  output logic [2:0]    ss,
  input  logic          SPI_done,
  input  logic [7:0]    EEP_data,
  output logic          flopOffset,
  output logic          flopGain,
  output logic [AW-1:0] ram_addr,
  output logic          ram_en,
  input  logic [7:0]    smpl,
  output logic [7:0]    tx_data,
  output logic          trmt,
  input  logic          tx_done,
  output logic          busy,
  output logic          dump_done
);

  typedef enum logic [3:0] {
    IDLE, OFF_CMD, OFF_W1, OFF_W2, GAIN_CMD, GAIN_W1, GAIN_W2,
    HDR, HDR_W, RD, LAT, TXW, DONE, ERR, ERR_W
  } state_t;

  state_t        state, nxt_state;
  logic [1:0]    ch_r;
  logic [2:0]    g_r;
  logic [2:0]    g_sel;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          last_smpl;

  always_comb begin
    case (dump_ch)
      2'd0:    g_sel = ch1_AFEgain;
      2'd1:    g_sel = ch2_AFEgain;
      default: g_sel = ch3_AFEgain;
    endcase
  end

  assign last_smpl = (cnt == (AW+1)'(DEPTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch_r    <= '0;
      g_r     <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      tx_data <= '0;
      trmt    <= 1'b0;
    end else begin
      state <= nxt_state;
      trmt  <= 1'b0;
      case (state)
        IDLE: if (dump) begin
          ch_r   <= dump_ch;
          g_r    <= g_sel;
          cnt    <= '0;
          rd_ptr <= (trig_addr == AW'(DEPTH-1)) ? '0 : trig_addr + 1'b1;
        end
        // tx_data and trmt are registered together so the byte is stable under the strobe
        HDR: begin
          tx_data <= {6'b110100, ch_r};
          trmt    <= 1'b1;
        end
        LAT: begin
          tx_data <= smpl;
          trmt    <= 1'b1;
        end
        ERR: begin
          tx_data <= 8'hEE;
          trmt    <= 1'b1;
        end
        TXW: if (tx_done) begin
          cnt    <= cnt + 1'b1;
          rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt_state  = state;
    wrt_SPI    = 1'b0;
    SPI_data   = '0;
    ss         = '0;
    flopOffset = 1'b0;
    flopGain   = 1'b0;
    ram_en     = 1'b0;
    ram_addr   = '0;
    busy       = 1'b1;
    dump_done  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (dump) nxt_state = (dump_ch == 2'd3) ? ERR : OFF_CMD;
      end
      OFF_CMD: begin
        ss        = EEP_SS;
        wrt_SPI   = 1'b1;
        SPI_data  = {2'b00, ch_r, g_r, 1'b0, 8'h00};
        nxt_state = OFF_W1;
      end
      OFF_W1: begin
        ss       = EEP_SS;
        SPI_data = SPI_DUMMY;
        if (SPI_done) begin
          wrt_SPI   = 1'b1;
          nxt_state = OFF_W2;
        end
      end
      OFF_W2: begin
        ss = EEP_SS;
        if (SPI_done) begin
          flopOffset = 1'b1;
          nxt_state  = GAIN_CMD;
        end
      end
      GAIN_CMD: begin
        ss        = EEP_SS;
        wrt_SPI   = 1'b1;
        SPI_data  = {2'b00, ch_r, g_r, 1'b1, 8'h00};
        nxt_state = GAIN_W1;
      end
      GAIN_W1: begin
        ss       = EEP_SS;
        SPI_data = SPI_DUMMY;
        if (SPI_done) begin
          wrt_SPI   = 1'b1;
          nxt_state = GAIN_W2;
        end
      end
      GAIN_W2: begin
        ss = EEP_SS;
        if (SPI_done) begin
          flopGain = 1'b1;
`ifdef DUMP_HEADER_EN
          nxt_state = HDR;
`else
          nxt_state = RD;
`endif
        end
      end
      HDR:   nxt_state = HDR_W;
      HDR_W: if (tx_done) nxt_state = RD;
      RD: begin
        ram_en    = 1'b1;
        ram_addr  = rd_ptr;
        nxt_state = LAT;
      end
      LAT: nxt_state = TXW;
      TXW: if (tx_done) nxt_state = last_smpl ? DONE : RD;
      DONE: begin
        busy      = 1'b0;
        dump_done = 1'b1;
        nxt_state = IDLE;
      end
      ERR:   nxt_state = ERR_W;
      ERR_W: if (tx_done) nxt_state = DONE;
      default: nxt_state = IDLE;
    endcase
  end

endmodule
